// File: rtl/md_stall_ctrl.sv
// Multiply/divide unit with HI/LO registers and D-stage stall generation.
// A fixed-latency busy period models the multi-cycle operation; results commit on the last busy edge.
module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [1:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_mthi,
    input  logic        E_mtlo,
    input  logic        D_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        issue;
    logic        commit;
    logic        mt_hi;
    logic        mt_lo;

    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_op;
    logic        div_by_zero;
    logic        commit_en;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Full 64-bit product; the low 64 bits of a sign-extended product equal the signed result.
    function automatic logic [63:0] mul64(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_unsigned ? {32'd0, a} : {{32{a[31]}}, a};
        bx = is_unsigned ? {32'd0, b} : {{32{b[31]}}, b};
        return ax * bx;
    endfunction

    // Sign-magnitude division: quotient truncates toward zero, remainder takes the dividend's sign.
    // 0x80000000 / -1 falls out naturally as magnitude 0x80000000 with a positive sign.
    function automatic logic [63:0] div32(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = !is_unsigned && a[31];
        b_neg = !is_unsigned && b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        r = a_neg ? (~r_mag + 32'd1) : r_mag;
        return {r, q};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        commit    = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (E_start) begin
                    issue     = 1'b1;
                    cnt_nxt   = E_op[1] ? DIV_N : MULT_N;
                    state_nxt = BUSY;
                end else begin
                    mt_hi = E_mthi;
                    mt_lo = E_mtlo;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= 2'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (issue) begin
            op_q <= E_op;
            a_q  <= E_A;
            b_q  <= E_B;
        end
    end

    always_comb begin
        prod        = mul64(op_q[0], a_q, b_q);
        {rem, quot} = div32(op_q[0], a_q, b_q);
        div_op      = op_q[1];
        div_by_zero = div_op && (b_q == 32'd0);
        res_hi      = div_op ? rem  : prod[63:32];
        res_lo      = div_op ? quot : prod[31:0];
        commit_en   = commit && !div_by_zero;
    end

    // An mt write can only occur in IDLE and a commit only in BUSY, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (commit_en) begin
            HI <= res_hi;
            LO <= res_lo;
        end else begin
            if (mt_hi) HI <= E_A;
            if (mt_lo) LO <= E_A;
        end
    end

    assign busy  = (state == BUSY);
    assign stall = D_md & (E_start | busy);

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with an arithmetic reference model compared every cycle.
module tb_md_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_start = 1'b0;
    logic [1:0]  E_op = 2'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        E_mthi = 1'b0;
    logic        E_mtlo = 1'b0;
    logic        D_md = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_start(E_start), .E_op(E_op), .E_A(E_A), .E_B(E_B),
        .E_mthi(E_mthi), .E_mtlo(E_mtlo), .D_md(D_md), .busy(busy), .stall(stall),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definitions, using 64-bit integers.
    function automatic void compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic upd, output logic [31:0] hi, output logic [31:0] lo);
        longint      la;
        longint      lb;
        longint      q;
        longint      r;
        logic [63:0] p;
        upd = 1'b1;
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            2'd0: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = 64'(la * lb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) upd = 1'b0;
                else begin
                    la = longint'($signed(a));
                    lb = longint'($signed(b));
                    q  = la / lb;
                    r  = la % lb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) upd = 1'b0;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    int          m_left = 0;
    logic        m_upd = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    always @(posedge clk or negedge reset) begin : model
        logic        u;
        logic [31:0] h;
        logic [31:0] l;
        if (!reset) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_upd  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_upd) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (E_start) begin
            compute(E_op, E_A, E_B, u, h, l);
            m_left <= E_op[1] ? 10 : 5;
            m_upd  <= u;
            p_hi   <= h;
            p_lo   <= l;
        end else begin
            if (E_mthi) m_hi <= E_A;
            if (E_mtlo) m_lo <= E_A;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("stall", {31'd0, stall}, {31'd0, D_md & (E_start | (m_left > 0))});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n, output int s);
        n = 0;
        s = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall === 1'b1) s++;
            tick();
        end
        if (n >= 40) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_n);
        int n;
        int s;
        E_start = 1'b1;
        E_op    = op;
        E_A     = a;
        E_B     = b;
        tick();
        E_start = 1'b0;
        E_A     = $urandom;
        E_B     = $urandom;
        wait_idle(n, s);
        chk("busy_len", 32'(n), 32'(exp_n));
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] v);
        E_mthi = h;
        E_mtlo = l;
        E_A    = v;
        tick();
        E_mthi = 1'b0;
        E_mtlo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        D_md    = 1'b1;
        E_start = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd1);
        E_start = 1'b0;
        D_md    = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // mult -2*3 with D_md held from the issue cycle
        D_md    = 1'b1;
        E_start = 1'b1;
        E_op    = 2'd0;
        E_A     = 32'hFFFF_FFFE;
        E_B     = 32'd3;
        #1;
        chk("issue_stall", {31'd0, stall}, 32'd1);
        tick();
        E_start = 1'b0;
        E_A     = 32'h1234_5678;
        E_B     = 32'h9ABC_DEF0;
        wait_idle(n, s);
        chk("mult_busy_len", 32'(n), 32'd5);
        chk("mult_stall_len", 32'(s), 32'd5);
        chk("post_commit_stall", {31'd0, stall}, 32'd0);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFA);
        D_md = 1'b0;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        chk("multu_HI", HI, 32'hFFFF_FFFE);
        chk("multu_LO", LO, 32'h0000_0001);

        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        do_op(2'd3, 32'd5, 32'd0, 10);
        chk("divu0_HI", HI, 32'h11);
        chk("divu0_LO", LO, 32'h22);

        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("divmin_LO", LO, 32'h8000_0000);
        chk("divmin_HI", HI, 32'h0);

        // Writes and a new start while busy are ignored
        E_start = 1'b1;
        E_op    = 2'd0;
        E_A     = 32'd3;
        E_B     = 32'd4;
        tick();
        E_op    = 2'd3;
        E_A     = 32'hABCD_0000;
        E_B     = 32'd0;
        E_mthi  = 1'b1;
        E_mtlo  = 1'b1;
        tick();
        tick();
        E_start = 1'b0;
        E_mthi  = 1'b0;
        E_mtlo  = 1'b0;
        wait_idle(n, s);
        chk("busy_mt_HI", HI, 32'h0);
        chk("busy_mt_LO", LO, 32'hC);
        mt(1'b1, 1'b0, 32'hABCD_0000);
        chk("idle_mthi", HI, 32'hABCD_0000);

        // Start beats simultaneous mt writes
        E_start = 1'b1;
        E_op    = 2'd3;
        E_A     = 32'd2;
        E_B     = 32'd0;
        E_mthi  = 1'b1;
        E_mtlo  = 1'b1;
        tick();
        E_start = 1'b0;
        E_mthi  = 1'b0;
        E_mtlo  = 1'b0;
        wait_idle(n, s);
        chk("prec_HI", HI, 32'hABCD_0000);
        chk("prec_LO", LO, 32'hC);

        mt(1'b1, 1'b1, 32'h5A5A);
        chk("mt_both_HI", HI, 32'h5A5A);
        chk("mt_both_LO", LO, 32'h5A5A);

        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 10);
        chk("div_pn_LO", LO, 32'hFFFF_FFFD);
        chk("div_pn_HI", HI, 32'd1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 10);
        do_op(2'd3, 32'd100, 32'd7, 10);
        chk("divu_LO", LO, 32'hE);
        chk("divu_HI", HI, 32'd2);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 5);
        chk("multmin_HI", HI, 32'h4000_0000);

        // Reset in the middle of a div, at cnt==3
        D_md    = 1'b1;
        E_start = 1'b1;
        E_op    = 2'd2;
        E_A     = 32'd100;
        E_B     = 32'd3;
        tick();
        E_start = 1'b0;
        repeat (7) tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        D_md  = 1'b0;
        repeat (12) tick();
        chk("discard_HI", HI, 32'd0);
        chk("discard_LO", LO, 32'd0);
        chk("discard_busy", {31'd0, busy}, 32'd0);

        do_op(2'd0, 32'd6, 32'd7, 5);
        chk("resume_LO", LO, 32'h2A);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
